systolic_feed_ctrl: RTL

//  Sequencer for the NxN FP32 PE array. On START it clears the array and streams
//  K operand steps from external A/B operand buffers onto the array's left/top buses.

---
 rtl/systolic_pkg.sv | 33 +++
 rtl/systolic_feed_ctrl_if.sv | 47 ++++
 rtl/systolic_skew_line.sv | 48 ++++
 rtl/systolic_feed_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared definitions for the systolic operand feed controller.
//                Holds the sequencer state encoding, the FP32 zero pattern
//                used for bus padding, and the lane-slice helper macro.
//  Revision    : 1.0  initial release
// ============================================================================

// Selects the 32-bit word of lane 'idx' from a packed N*32 bus.
`ifndef SYSTOLIC_LANE
`define SYSTOLIC_LANE(vec, idx) vec[(idx)*32 +: 32]
`endif

package systolic_pkg;

    // Sequencer states
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_clr   = 3'd1;
    localparam logic [2:0] c_st_feed  = 3'd2;
    localparam logic [2:0] c_st_flush = 3'd3;
    localparam logic [2:0] c_st_drain = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    // +0.0 in IEEE-754 single precision; PEs treat it as a null product.
    localparam logic [31:0] c_fp32_zero = 32'h0000_0000;

    // Width of the shared phase counter (covers CLR/ISSUE/FLUSH/DRAIN lengths).
    localparam int c_cnt_w = 16;

endpackage

`default_nettype wire

// File: rtl/systolic_feed_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_feed_ctrl_if
//  Description : Job-control, operand-buffer and PE-array feed signals of the
//                systolic feed controller.
//                master : host / operand-buffer side (drives START, K_LEN,
//                         A_RDATA, B_RDATA)
//                slave  : the feed controller itself
//  Ports       : START, K_LEN              job request and inner dimension
//                BUSY, DONE, RES_VALID     job status
//                ARRAY_RST_N               active-low PE array clear
//                RD_EN, RD_ADDR            operand buffer read request
//                A_RDATA, B_RDATA          operand buffer read data (N*32)
//                LEFT_BUS, TOP_BUS         PE array edge feeds (N*32)
//  Revision    : 1.0  initial release
// ============================================================================
interface systolic_feed_ctrl_if #(
    parameter int N  = 4,
    parameter int KW = 8
);
    logic            START;
    logic [KW-1:0]   K_LEN;
    logic            BUSY;
    logic            DONE;
    logic            RES_VALID;
    logic            ARRAY_RST_N;
    logic            RD_EN;
    logic [KW-1:0]   RD_ADDR;
    logic [N*32-1:0] A_RDATA;
    logic [N*32-1:0] B_RDATA;
    logic [N*32-1:0] LEFT_BUS;
    logic [N*32-1:0] TOP_BUS;

    modport master (
        output START, K_LEN, A_RDATA, B_RDATA,
        input  BUSY, DONE, RES_VALID, ARRAY_RST_N, RD_EN, RD_ADDR,
               LEFT_BUS, TOP_BUS
    );

    modport slave (
        input  START, K_LEN, A_RDATA, B_RDATA,
        output BUSY, DONE, RES_VALID, ARRAY_RST_N, RD_EN, RD_ADDR,
               LEFT_BUS, TOP_BUS
    );
endinterface

`default_nettype wire

// File: rtl/systolic_skew_line.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_skew_line
//  Description : Per-lane delay line. Delays i_din by DEPTH clock cycles;
//                DEPTH = 0 is a plain wire. Used to stagger lanes for arrays
//                whose PEs register their pass-through operands.
//  Ports       : CLK    clock, rising edge
//                RST_N  asynchronous active-low reset (clears the line)
//                i_din  lane input  (W bits)
//                o_dout lane output (W bits), i_din delayed DEPTH cycles
//  Revision    : 1.0  initial release
// ============================================================================
module systolic_skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 32
) (
    input  wire logic         CLK,
    input  wire logic         RST_N,
    input  wire logic [W-1:0] i_din,
    output logic      [W-1:0] o_dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_dout = i_din;
        end else begin : g_shift
            logic [W-1:0] r_pipe [DEPTH];

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    for (int d = 0; d < DEPTH; d++) begin
                        r_pipe[d] <= '0;
                    end
                end else begin
                    r_pipe[0] <= i_din;
                    for (int d = 1; d < DEPTH; d++) begin
                        r_pipe[d] <= r_pipe[d-1];
                    end
                end
            end

            assign o_dout = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/systolic_feed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_feed_ctrl
//  Description : Sequencer for an NxN FP32 PE array. On START it clears the
//                array for CLR_CYC cycles, streams K_LEN operand steps from
//                the A/B operand buffers onto LEFT_BUS/TOP_BUS (one operand
//                cycle followed by ISSUE_GAP-1 zero cycles per step), flushes
//                the read pipe, waits DRAIN_CYC cycles and pulses DONE.
//  Config      : SYSTOLIC_SKEW_EN - when defined, lane i of each bus is
//                delayed by i extra cycles and FLUSH lasts N cycles;
//                otherwise all lanes are aligned and FLUSH lasts 1 cycle.
//  Ports       : CLK    clock, rising edge
//                RST_N  asynchronous active-low reset
//                bus    systolic_feed_ctrl_if.slave (job control, operand
//                       buffer read port, PE array feeds)
//  Revision    : 1.0  initial release
// ============================================================================
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int N         = 4,
    parameter int KW        = 8,
    parameter int ISSUE_GAP = 4,
    parameter int DRAIN_CYC = 8,
    parameter int CLR_CYC   = 2
) (
    input  wire logic          CLK,
    input  wire logic          RST_N,
    systolic_feed_ctrl_if.slave bus
);

`ifdef SYSTOLIC_SKEW_EN
    // The deepest lane needs N-1 extra cycles to leave the skew registers.
    localparam int c_flush_cyc = N;
`else
    localparam int c_flush_cyc = 1;
`endif

    localparam logic [c_cnt_w-1:0] c_clr_last   = c_cnt_w'(CLR_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last   = c_cnt_w'(ISSUE_GAP - 1);
    localparam logic [c_cnt_w-1:0] c_flush_last = c_cnt_w'(c_flush_cyc - 1);
    localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(DRAIN_CYC - 1);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    // One bit wider than K_LEN so the last step index never wraps.
    logic [KW:0]        r_k;
    logic [KW:0]        w_k_nxt;
    logic [KW:0]        w_k_inc;
    logic [KW-1:0]      r_klen;
    logic               r_res_valid;
    logic               r_array_rst_n;
    logic               w_accept;
    logic               w_rd_en;

    assign w_accept = (r_state == c_st_idle) && bus.START;
    assign w_k_inc  = r_k + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        case (r_state)
            c_st_idle: begin
                if (bus.START) begin
                    w_state_nxt = c_st_clr;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = '0;
                end
            end
            c_st_clr: begin
                if (r_cnt == c_clr_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_klen == '0) ? c_st_done : c_st_feed;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_feed: begin
                if (r_cnt == c_gap_last) begin
                    w_cnt_nxt = '0;
                    if (w_k_inc == {1'b0, r_klen}) begin
                        w_state_nxt = c_st_flush;
                    end else begin
                        w_k_nxt = w_k_inc;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_flush: begin
                if (r_cnt == c_flush_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_st_drain;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_drain: begin
                if (r_cnt == c_drain_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_st_done;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
                w_k_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_k           <= '0;
            r_klen        <= '0;
            r_res_valid   <= 1'b0;
            r_array_rst_n <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_k           <= w_k_nxt;
            // Registered from the next state so the PE clear is glitch-free.
            r_array_rst_n <= (w_state_nxt != c_st_clr);
            if (w_accept) begin
                r_klen      <= bus.K_LEN;
                r_res_valid <= 1'b0;
            end else if (r_state == c_st_done) begin
                r_res_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand read and bus registers
    // ------------------------------------------------------------------
    // The buffer returns data the cycle after RD_EN; r_rd_vld marks that
    // cycle so the bus register takes real data only then and +0.0 otherwise.
    logic            r_rd_vld;
    logic [N*32-1:0] r_left;
    logic [N*32-1:0] r_top;

    assign w_rd_en = (r_state == c_st_feed) && (r_cnt == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_vld <= 1'b0;
            r_left   <= '0;
            r_top    <= '0;
        end else begin
            r_rd_vld <= w_rd_en;
            r_left   <= r_rd_vld ? bus.A_RDATA : {N{c_fp32_zero}};
            r_top    <= r_rd_vld ? bus.B_RDATA : {N{c_fp32_zero}};
        end
    end

`ifdef SYSTOLIC_SKEW_EN
    logic [N*32-1:0] w_left_skew;
    logic [N*32-1:0] w_top_skew;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_skew
            systolic_skew_line #(
                .DEPTH (gi),
                .W     (32)
            ) u_left_skew (
                .CLK    (CLK),
                .RST_N  (RST_N),
                .i_din  (`SYSTOLIC_LANE(r_left, gi)),
                .o_dout (`SYSTOLIC_LANE(w_left_skew, gi))
            );
            systolic_skew_line #(
                .DEPTH (gi),
                .W     (32)
            ) u_top_skew (
                .CLK    (CLK),
                .RST_N  (RST_N),
                .i_din  (`SYSTOLIC_LANE(r_top, gi)),
                .o_dout (`SYSTOLIC_LANE(w_top_skew, gi))
            );
        end
    endgenerate

    assign bus.LEFT_BUS = w_left_skew;
    assign bus.TOP_BUS  = w_top_skew;
`else
    assign bus.LEFT_BUS = r_left;
    assign bus.TOP_BUS  = r_top;
`endif

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign bus.BUSY        = (r_state != c_st_idle);
    assign bus.DONE        = (r_state == c_st_done);
    assign bus.RES_VALID   = r_res_valid;
    assign bus.ARRAY_RST_N = r_array_rst_n;
    assign bus.RD_EN       = w_rd_en;
    assign bus.RD_ADDR     = w_rd_en ? r_k[KW-1:0] : '0;

endmodule

`default_nettype wire
